// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block/word geometry, round count and the
// block controller state encoding. Imported by the controller, the round
// counter and the compression core.
package sha256_pkg;

  localparam int BLK_W  = 512;
  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;
  localparam int RIDX_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    UPDATE,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/sha256_round_counter.sv
// Round index counter for the SHA-256 compression loop.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clr_i       return the count to 0 (takes priority over en_i)
//   en_i        advance the count by one
//   cnt_o       current round index t (selects K_t)
//   last_o      high while t is the final round (63)
// The count never advances past the final round when the owner stops
// enabling it there, so it holds its last value between blocks.
module sha256_round_counter
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [RIDX_W-1:0] cnt_o,
  output logic              last_o
);

  logic [RIDX_W-1:0] cnt_q;
  logic [RIDX_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + RIDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == RIDX_W'(ROUNDS - 1));

endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 block controller: accepts one padded 512-bit block at a time,
// holds it on the message-schedule generator's M bus, raises W_start, and
// issues round enables/indices aligned to each W_t. Pulses hash_update at
// the end of every block and presents digest_valid after the last block
// of a message until downstream consumes it.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   blk_valid/blk_ready        upstream block handshake
//   blk_data, blk_last         block (word 0 in [511:480]), last-of-message
//   m_out                      accepted block, drives generator M
//   w_start                    level to generator W_start
//   round_en, round_idx        round t executes this cycle / t (0..63)
//   first_blk                  current block is first of its message
//   hash_update                one-cycle pulse: add working vars into H
//   digest_valid/digest_ready  final digest handshake
//   busy                       controller not idle
// All outputs are registered from the next-state decode so that each one
// reads exactly as the state it describes and is 0 while reset is held.
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int W_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blk_valid,
  input  logic [BLK_W-1:0]  blk_data,
  input  logic              blk_last,
  output logic              blk_ready,
  output logic [BLK_W-1:0]  m_out,
  output logic              w_start,
  output logic              round_en,
  output logic [RIDX_W-1:0] round_idx,
  output logic              first_blk,
  output logic              hash_update,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic              busy
);

  localparam int WAIT_W = (W_LAT > 1) ? $clog2(W_LAT) : 1;

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              last_q, last_d;
  logic              first_pending_q, first_pending_d;
  logic              first_blk_q, first_blk_d;
  logic [BLK_W-1:0]  m_q;
  logic              blk_ready_q, w_start_q, round_en_q;
  logic              hash_update_q, digest_valid_q, busy_q;
  logic              accept;
  logic              cnt_clr, cnt_en, cnt_last;

  sha256_round_counter u_round_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (round_idx),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    last_d          = last_q;
    first_pending_d = first_pending_q;
    first_blk_d     = first_blk_q;
    accept          = 1'b0;
    cnt_clr         = 1'b0;
    cnt_en          = 1'b0;
    case (state_q)
      IDLE: begin
        // blk_ready_q is low for the first cycle after reset; never take a
        // block the upstream did not see offered.
        if (blk_valid && blk_ready_q) begin
          accept      = 1'b1;
          last_d      = blk_last;
          first_blk_d = first_pending_q;
          wait_d      = '0;
          cnt_clr     = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        // Covers the generator latency until W_0 appears.
        if (wait_q == WAIT_W'(W_LAT - 1)) begin
          wait_d  = '0;
          state_d = ROUND;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ROUND: begin
        // Stop counting at the final round so round_idx holds 63 afterwards.
        if (cnt_last) begin
          state_d = UPDATE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      UPDATE: begin
        first_pending_d = 1'b0;
        state_d         = last_q ? DONE : IDLE;
      end
      DONE: begin
        if (digest_ready) begin
          first_pending_d = 1'b1;
          first_blk_d     = 1'b0;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      wait_q          <= '0;
      last_q          <= 1'b0;
      first_pending_q <= 1'b1;
      first_blk_q     <= 1'b0;
      m_q             <= '0;
      blk_ready_q     <= 1'b0;
      w_start_q       <= 1'b0;
      round_en_q      <= 1'b0;
      hash_update_q   <= 1'b0;
      digest_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_q          <= wait_d;
      last_q          <= last_d;
      first_pending_q <= first_pending_d;
      first_blk_q     <= first_blk_d;
      if (accept) begin
        m_q <= blk_data;
      end
      blk_ready_q    <= (state_d == IDLE);
      w_start_q      <= (state_d == LOAD) || (state_d == ROUND);
      round_en_q     <= (state_d == ROUND);
      hash_update_q  <= (state_d == UPDATE);
      digest_valid_q <= (state_d == DONE);
      busy_q         <= (state_d != IDLE);
    end
  end

  assign blk_ready    = blk_ready_q;
  assign m_out        = m_q;
  assign w_start      = w_start_q;
  assign round_en     = round_en_q;
  assign first_blk    = first_blk_q;
  assign hash_update  = hash_update_q;
  assign digest_valid = digest_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Bench for sha256_block_ctrl: directed "abc" and two-block messages, a
// mid-round reset, then randomized messages with random gaps, ignored
// blk_valid noise and random digest_ready delays. Expected timing is derived
// from the cycle offset after each acceptance; a behavioural message
// schedule stands in for the W generator.
module tb_sha256_block_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         blk_valid = 1'b0;
  logic [511:0] blk_data = '0;
  logic         blk_last = 1'b0;
  logic         digest_ready = 1'b0;
  logic         blk_ready, w_start, round_en, first_blk;
  logic         hash_update, digest_valid, busy;
  logic [511:0] m_out;
  logic [5:0]   round_idx;

  int n_chk = 0;
  int n_err = 0;
  logic msg_first = 1'b1;
  logic [31:0] wexp [64];

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

  sha256_block_ctrl #(.W_LAT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .blk_valid    (blk_valid),
    .blk_data     (blk_data),
    .blk_last     (blk_last),
    .blk_ready    (blk_ready),
    .m_out        (m_out),
    .w_start      (w_start),
    .round_en     (round_en),
    .round_idx    (round_idx),
    .first_blk    (first_blk),
    .hash_update  (hash_update),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic calc_sched(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) wexp[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(wexp[t-15], 7) ^ rotr(wexp[t-15], 18) ^ (wexp[t-15] >> 3);
      s1 = rotr(wexp[t-2], 17) ^ rotr(wexp[t-2], 19) ^ (wexp[t-2] >> 10);
      wexp[t] = wexp[t-16] + s0 + wexp[t-7] + s1;
    end
  endtask

  task automatic rand_blk(output logic [511:0] b);
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
  endtask

  task automatic noise();
    logic [511:0] g;
    rand_blk(g);
    blk_valid = 1'($urandom_range(0, 1));
    blk_data  = g;
    blk_last  = 1'($urandom_range(0, 1));
  endtask

  // Entered and left at the falling edge of an idle cycle, inputs not yet
  // driven for that cycle. rst_at>0 aborts the block with a reset there.
  task automatic run_block(input logic [511:0] data, input logic last, input int gap,
                           input int dly, input int rst_at);
    logic abc;
    abc = (data == ABC);
    for (int g = 0; g < gap; g++) begin
      blk_valid = 1'b0;
      @(negedge clk);
      chk("gap_ready", 512'(blk_ready), 512'(1'b1));
      chk("gap_busy", 512'(busy), 512'(1'b0));
    end
    blk_valid = 1'b1;
    blk_data  = data;
    blk_last  = last;
    @(posedge clk);
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        reset = 1'b1;
        blk_valid = 1'b0;
        #1;
        chk("rst_w_start", 512'(w_start), 512'(1'b0));
        chk("rst_round_en", 512'(round_en), 512'(1'b0));
        chk("rst_round_idx", 512'(round_idx), 512'(6'd0));
        chk("rst_m_out", m_out, 512'(0));
        chk("rst_busy", 512'(busy), 512'(1'b0));
        chk("rst_first_blk", 512'(first_blk), 512'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        msg_first = 1'b1;
        @(negedge clk);
        chk("rst_ready", 512'(blk_ready), 512'(1'b1));
        return;
      end
      if (k == 1) calc_sched(m_out);
      chk("w_start", 512'(w_start), 512'(k <= 67));
      chk("round_en", 512'(round_en), 512'(k >= 4 && k <= 67));
      if (k >= 4 && k <= 67) chk("round_idx", 512'(round_idx), 512'(k - 4));
      chk("hash_update", 512'(hash_update), 512'(k == 68));
      chk("busy_ready", 512'(blk_ready), 512'(1'b0));
      chk("busy_dv", 512'(digest_valid), 512'(1'b0));
      chk("busy", 512'(busy), 512'(1'b1));
      chk("m_out", m_out, data);
      chk("first_blk", 512'(first_blk), 512'(msg_first));
      if (abc && k == 4)  chk("w_t0", 512'(wexp[round_idx]), 512'(32'h61626380));
      if (abc && k == 20) chk("w_t16", 512'(wexp[round_idx]), 512'(32'h61626380));
      if (abc && k == 67) chk("w_t63", 512'(wexp[round_idx]), 512'(32'h12B1EDEB));
      noise();
    end
    msg_first = 1'b0;
    @(negedge clk);
    chk("m_out_69", m_out, data);
    if (!last) begin
      chk("ready_69", 512'(blk_ready), 512'(1'b1));
      chk("dv_69", 512'(digest_valid), 512'(1'b0));
      chk("busy_69", 512'(busy), 512'(1'b0));
    end else begin
      for (int d = 0; d < dly; d++) begin
        chk("done_dv", 512'(digest_valid), 512'(1'b1));
        chk("done_ready", 512'(blk_ready), 512'(1'b0));
        chk("done_m_out", m_out, data);
        noise();
        @(negedge clk);
      end
      chk("done_dv", 512'(digest_valid), 512'(1'b1));
      chk("done_ready", 512'(blk_ready), 512'(1'b0));
      digest_ready = 1'b1;
      noise();
      @(negedge clk);
      digest_ready = 1'b0;
      blk_valid = 1'b0;
      chk("rel_ready", 512'(blk_ready), 512'(1'b1));
      chk("rel_dv", 512'(digest_valid), 512'(1'b0));
      chk("rel_first_blk", 512'(first_blk), 512'(1'b0));
      chk("rel_m_out", m_out, data);
      msg_first = 1'b1;
    end
  endtask

  initial begin
    logic [511:0] b1, b2, bd;
    int nb;
    repeat (2) @(negedge clk);
    chk("reset_ready", 512'(blk_ready), 512'(1'b0));
    chk("reset_busy", 512'(busy), 512'(1'b0));
    chk("reset_m_out", m_out, 512'(0));
    chk("reset_w_start", 512'(w_start), 512'(1'b0));
    chk("reset_round_idx", 512'(round_idx), 512'(6'd0));
    chk("reset_dv", 512'(digest_valid), 512'(1'b0));
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 512'(blk_ready), 512'(1'b1));

    run_block(ABC, 1'b1, 0, 6, 0);

    rand_blk(b1);
    rand_blk(b2);
    run_block(b1, 1'b0, 0, 0, 0);
    run_block(b2, 1'b1, 0, 3, 0);

    run_block(b1, 1'b0, 1, 0, 0);
    run_block(b2, 1'b1, 0, 0, 30);
    run_block(ABC, 1'b1, 2, 2, 0);

    for (int m = 0; m < 6; m++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        rand_blk(bd);
        run_block(bd, 1'(b == nb - 1), $urandom_range(0, 3), $urandom_range(0, 5), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
